// File: rtl/compressor_pkg.sv
// Shared constants and elaboration-time planning for the compressor tree.
// Column heights and per-stage full/half adder counts are derived here.
package compressor_pkg;

   localparam int NUM_COLS   = 21;
   localparam int OUT_W      = 22;
   localparam int NUM_STAGES = 5;

   typedef logic [7:0] cnt_t;

   typedef struct packed {
      cnt_t height;
      cnt_t full;
      cnt_t half;
   } col_plan_t;

   typedef col_plan_t [OUT_W-1:0] stage_plan_t;

   function automatic int h(input int i);
      if (i < 0 || i >= NUM_COLS) return 0;
      return (i + 1 < NUM_COLS - i) ? i + 1 : NUM_COLS - i;
   endfunction

   // Dadda height targets 9, 6, 4, 3, 2 for stages 0..4.
   function automatic int stage_target(input int s);
      int d;
      d = 2;
      for (int k = 0; k < NUM_STAGES - 1 - s; k++) d = (d * 3) / 2;
      return d;
   endfunction

   // Column heights entering stage s, plus adder counts used within stage s.
   function automatic stage_plan_t stage_plan(input int s);
      int ht [OUT_W];
      int fa [OUT_W];
      int ha [OUT_W];
      int tot;
      int d;
      int carry;
      stage_plan_t p;
      p = '0;
      for (int i = 0; i < OUT_W; i++) begin
         ht[i] = h(i);
         fa[i] = 0;
         ha[i] = 0;
      end
      for (int st = 0; st <= s; st++) begin
         for (int i = 0; i < OUT_W; i++) begin
            fa[i] = 0;
            ha[i] = 0;
         end
         if (st < NUM_STAGES) begin
            d     = stage_target(st);
            carry = 0;
            for (int i = 0; i < OUT_W; i++) begin
               tot = ht[i] + carry;
               while (tot > d) begin
                  if (tot == d + 1) begin
                     ha[i] = ha[i] + 1;
                     tot   = tot - 1;
                  end else begin
                     fa[i] = fa[i] + 1;
                     tot   = tot - 2;
                  end
               end
               carry = fa[i] + ha[i];
            end
         end
         if (st < s) begin
            carry = 0;
            for (int i = 0; i < OUT_W; i++) begin
               tot   = ht[i] - 2 * fa[i] - ha[i] + carry;
               carry = fa[i] + ha[i];
               ht[i] = tot;
            end
         end
      end
      for (int i = 0; i < OUT_W; i++) begin
         p[i].height = cnt_t'(ht[i]);
         p[i].full   = cnt_t'(fa[i]);
         p[i].half   = cnt_t'(ha[i]);
      end
      return p;
   endfunction

   function automatic int col_off(input stage_plan_t p, input int c);
      int off;
      off = 0;
      for (int i = 0; i < OUT_W; i++) begin
         if (i < c) off = off + int'(p[i].height);
      end
      return off;
   endfunction

   function automatic int stage_w(input stage_plan_t p);
      return col_off(p, OUT_W);
   endfunction

   // Sums plus pass-through bits a column keeps before incoming carries are appended.
   function automatic int own_bits(input stage_plan_t p, input int c);
      if (c < 0 || c >= OUT_W) return 0;
      return int'(p[c].height) - 2 * int'(p[c].full) - int'(p[c].half);
   endfunction

endpackage

// File: rtl/full_adder.sv
// 3:2 counter used as the basic reduction cell of the compressor tree.
module full_adder (
   input  logic a,
   input  logic b,
   input  logic ci,
   output logic s,
   output logic co
);

   assign s  = a ^ b ^ ci;
   assign co = (a & b) | (ci & (a ^ b));

endmodule

// File: rtl/compressor.sv
// Dadda carry-save reduction of 21 weighted bit columns, a 22-bit final add
// and a single output register.
module compressor
   import compressor_pkg::*;
(
   input  logic        clk,
   input  logic        rst,
   input  logic [0:0]  src0,
   input  logic [1:0]  src1,
   input  logic [2:0]  src2,
   input  logic [3:0]  src3,
   input  logic [4:0]  src4,
   input  logic [5:0]  src5,
   input  logic [6:0]  src6,
   input  logic [7:0]  src7,
   input  logic [8:0]  src8,
   input  logic [9:0]  src9,
   input  logic [10:0] src10,
   input  logic [9:0]  src11,
   input  logic [8:0]  src12,
   input  logic [7:0]  src13,
   input  logic [6:0]  src14,
   input  logic [5:0]  src15,
   input  logic [4:0]  src16,
   input  logic [3:0]  src17,
   input  logic [2:0]  src18,
   input  logic [1:0]  src19,
   input  logic [0:0]  src20,
   output logic        dst0,  dst1,  dst2,  dst3,  dst4,  dst5,  dst6,  dst7,
   output logic        dst8,  dst9,  dst10, dst11, dst12, dst13, dst14, dst15,
   output logic        dst16, dst17, dst18, dst19, dst20, dst21
);

   localparam stage_plan_t PLAN_IN  = stage_plan(0);
   localparam stage_plan_t PLAN_FIN = stage_plan(NUM_STAGES);
   localparam int          IN_W     = stage_w(PLAN_IN);
   localparam int          FIN_W    = stage_w(PLAN_FIN);

   logic [IN_W-1:0]  col_bits;
   logic [FIN_W-1:0] fin_bits;
   logic [OUT_W-1:0] op_a;
   logic [OUT_W-1:0] op_b;
   logic [OUT_W-1:0] sum_d;
   logic [OUT_W-1:0] dst_q;

   // Stage-0 layout is column-major with column 0 at the LSB end.
   assign col_bits = {src20, src19, src18, src17, src16, src15, src14,
                      src13, src12, src11, src10, src9,  src8,  src7,
                      src6,  src5,  src4,  src3,  src2,  src1,  src0};

   for (genvar gi = 0; gi < NUM_STAGES; gi++) begin : g_stage
      localparam stage_plan_t P_IN  = stage_plan(gi);
      localparam stage_plan_t P_OUT = stage_plan(gi + 1);

      logic [stage_w(P_IN)-1:0]  cur;
      logic [stage_w(P_OUT)-1:0] nxt;

      if (gi == 0) begin : g_first
         assign cur = col_bits;
      end else begin : g_link
         assign cur = g_stage[gi-1].nxt;
      end

      // Each output column holds: FA sums, HA sums, untouched bits, then carries from below.
      for (genvar gc = 0; gc < OUT_W; gc++) begin : g_col
         for (genvar gk = 0; gk < int'(P_IN[gc].full); gk++) begin : g_fa
            full_adder u_fa (
               .a  (cur[col_off(P_IN, gc) + 3*gk]),
               .b  (cur[col_off(P_IN, gc) + 3*gk + 1]),
               .ci (cur[col_off(P_IN, gc) + 3*gk + 2]),
               .s  (nxt[col_off(P_OUT, gc) + gk]),
               .co (nxt[col_off(P_OUT, gc + 1) + own_bits(P_IN, gc + 1) + gk])
            );
         end
         for (genvar gk = 0; gk < int'(P_IN[gc].half); gk++) begin : g_ha
            assign nxt[col_off(P_OUT, gc) + int'(P_IN[gc].full) + gk] =
               cur[col_off(P_IN, gc) + 3*int'(P_IN[gc].full) + 2*gk] ^
               cur[col_off(P_IN, gc) + 3*int'(P_IN[gc].full) + 2*gk + 1];
            assign nxt[col_off(P_OUT, gc + 1) + own_bits(P_IN, gc + 1) + int'(P_IN[gc].full) + gk] =
               cur[col_off(P_IN, gc) + 3*int'(P_IN[gc].full) + 2*gk] &
               cur[col_off(P_IN, gc) + 3*int'(P_IN[gc].full) + 2*gk + 1];
         end
         for (genvar gk = 0;
              gk < int'(P_IN[gc].height) - 3*int'(P_IN[gc].full) - 2*int'(P_IN[gc].half);
              gk++) begin : g_pass
            assign nxt[col_off(P_OUT, gc) + int'(P_IN[gc].full) + int'(P_IN[gc].half) + gk] =
               cur[col_off(P_IN, gc) + 3*int'(P_IN[gc].full) + 2*int'(P_IN[gc].half) + gk];
         end
      end
   end

   assign fin_bits = g_stage[NUM_STAGES-1].nxt;

   // After the last stage every column is at most two bits tall.
   for (genvar gi = 0; gi < OUT_W; gi++) begin : g_final
      if (PLAN_FIN[gi].height >= cnt_t'(1)) begin : g_a_bit
         assign op_a[gi] = fin_bits[col_off(PLAN_FIN, gi)];
      end else begin : g_a_zero
         assign op_a[gi] = 1'b0;
      end
      if (PLAN_FIN[gi].height >= cnt_t'(2)) begin : g_b_bit
         assign op_b[gi] = fin_bits[col_off(PLAN_FIN, gi) + 1];
      end else begin : g_b_zero
         assign op_b[gi] = 1'b0;
      end
   end

   assign sum_d = op_a + op_b;

   always_ff @(posedge clk) begin
      if (rst) begin
         dst_q <= '0;
      end else begin
         dst_q <= sum_d;
      end
   end

   assign {dst21, dst20, dst19, dst18, dst17, dst16, dst15, dst14,
           dst13, dst12, dst11, dst10, dst9,  dst8,  dst7,  dst6,
           dst5,  dst4,  dst3,  dst2,  dst1,  dst0} = dst_q;

endmodule

// File: tb/tb_compressor.sv
// Directed and randomized checks of the registered weighted-popcount compressor.
module tb_compressor;

   logic        clk = 1'b0;
   logic        rst;
   logic [10:0] col_v [21];

   logic [0:0]  src0;   logic [1:0]  src1;   logic [2:0]  src2;   logic [3:0]  src3;
   logic [4:0]  src4;   logic [5:0]  src5;   logic [6:0]  src6;   logic [7:0]  src7;
   logic [8:0]  src8;   logic [9:0]  src9;   logic [10:0] src10;  logic [9:0]  src11;
   logic [8:0]  src12;  logic [7:0]  src13;  logic [6:0]  src14;  logic [5:0]  src15;
   logic [4:0]  src16;  logic [3:0]  src17;  logic [2:0]  src18;  logic [1:0]  src19;
   logic [0:0]  src20;

   logic dst0,  dst1,  dst2,  dst3,  dst4,  dst5,  dst6,  dst7,  dst8,  dst9,  dst10;
   logic dst11, dst12, dst13, dst14, dst15, dst16, dst17, dst18, dst19, dst20, dst21;
   logic [21:0] dst_w;

   int total = 0;
   int bad   = 0;

   assign src0  = col_v[0][0:0];   assign src1  = col_v[1][1:0];   assign src2  = col_v[2][2:0];
   assign src3  = col_v[3][3:0];   assign src4  = col_v[4][4:0];   assign src5  = col_v[5][5:0];
   assign src6  = col_v[6][6:0];   assign src7  = col_v[7][7:0];   assign src8  = col_v[8][8:0];
   assign src9  = col_v[9][9:0];   assign src10 = col_v[10][10:0]; assign src11 = col_v[11][9:0];
   assign src12 = col_v[12][8:0];  assign src13 = col_v[13][7:0];  assign src14 = col_v[14][6:0];
   assign src15 = col_v[15][5:0];  assign src16 = col_v[16][4:0];  assign src17 = col_v[17][3:0];
   assign src18 = col_v[18][2:0];  assign src19 = col_v[19][1:0];  assign src20 = col_v[20][0:0];

   assign dst_w = {dst21, dst20, dst19, dst18, dst17, dst16, dst15, dst14, dst13, dst12, dst11,
                   dst10, dst9,  dst8,  dst7,  dst6,  dst5,  dst4,  dst3,  dst2,  dst1,  dst0};

   compressor dut (
      .clk   (clk),   .rst   (rst),
      .src0  (src0),  .src1  (src1),  .src2  (src2),  .src3  (src3),  .src4  (src4),
      .src5  (src5),  .src6  (src6),  .src7  (src7),  .src8  (src8),  .src9  (src9),
      .src10 (src10), .src11 (src11), .src12 (src12), .src13 (src13), .src14 (src14),
      .src15 (src15), .src16 (src16), .src17 (src17), .src18 (src18), .src19 (src19),
      .src20 (src20),
      .dst0  (dst0),  .dst1  (dst1),  .dst2  (dst2),  .dst3  (dst3),  .dst4  (dst4),
      .dst5  (dst5),  .dst6  (dst6),  .dst7  (dst7),  .dst8  (dst8),  .dst9  (dst9),
      .dst10 (dst10), .dst11 (dst11), .dst12 (dst12), .dst13 (dst13), .dst14 (dst14),
      .dst15 (dst15), .dst16 (dst16), .dst17 (dst17), .dst18 (dst18), .dst19 (dst19),
      .dst20 (dst20), .dst21 (dst21)
   );

   always #5 clk = ~clk;

   function automatic int col_h(input int i);
      return (i + 1 < 21 - i) ? i + 1 : 21 - i;
   endfunction

   function automatic logic [10:0] col_mask(input int i);
      return 11'((1 << col_h(i)) - 1);
   endfunction

   function automatic logic [21:0] model_sum();
      logic [21:0] s;
      s = '0;
      for (int i = 0; i < 21; i++) s = s + (22'($countones(col_v[i] & col_mask(i))) << i);
      return s;
   endfunction

   task automatic set_all(input logic ones);
      for (int i = 0; i < 21; i++) col_v[i] = ones ? col_mask(i) : 11'h000;
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      set_all(1'b1);
      tick();
      total++;
      if (dst_w !== 22'h000000) begin
         bad++;
         $display("FAIL reset_ones: dst=%06h required=%06h", dst_w, 22'h000000);
      end else $display("reset_ones: dst=%06h", dst_w);
      col_v[10] = 11'h555;
      tick();
      total++;
      if (dst_w !== 22'h000000) begin
         bad++;
         $display("FAIL reset_hold: dst=%06h required=%06h", dst_w, 22'h000000);
      end else $display("reset_hold: dst=%06h", dst_w);
      rst = 1'b0;
   endtask

   task automatic test_extremes();
      set_all(1'b0);
      tick();
      total++;
      if (dst_w !== 22'h000000) begin
         bad++;
         $display("FAIL all_zero: dst=%06h required=%06h", dst_w, 22'h000000);
      end else $display("all_zero: dst=%06h", dst_w);
      set_all(1'b1);
      tick();
      total++;
      if (dst_w !== 22'h3FF001) begin
         bad++;
         $display("FAIL all_ones: dst=%06h required=%06h", dst_w, 22'h3FF001);
      end else $display("all_ones: dst=%06h", dst_w);
   endtask

   task automatic test_single_cols();
      int          col_t [8] = '{20, 10, 0, 1, 1, 5, 19, 15};
      logic [10:0] val_t [8] = '{11'h001, 11'h7FF, 11'h001, 11'h002, 11'h001, 11'h025, 11'h003, 11'h03F};
      logic [21:0] exp_t [8] = '{22'h100000, 22'h002C00, 22'h000001, 22'h000002,
                                 22'h000002, 22'h000060, 22'h100000, 22'h030000};
      for (int t = 0; t < 8; t++) begin
         set_all(1'b0);
         col_v[col_t[t]] = val_t[t];
         tick();
         total++;
         if (dst_w !== exp_t[t]) begin
            bad++;
            $display("FAIL single_col[%0d] src%0d=%03h: dst=%06h required=%06h",
                     t, col_t[t], val_t[t], dst_w, exp_t[t]);
         end else $display("single_col[%0d] src%0d=%03h: dst=%06h", t, col_t[t], val_t[t], dst_w);
      end
   endtask

   task automatic test_reset_mid();
      set_all(1'b1);
      tick();
      total++;
      if (dst_w !== 22'h3FF001) begin
         bad++;
         $display("FAIL mid_before: dst=%06h required=%06h", dst_w, 22'h3FF001);
      end else $display("mid_before: dst=%06h", dst_w);
      rst = 1'b1;
      tick();
      total++;
      if (dst_w !== 22'h000000) begin
         bad++;
         $display("FAIL mid_reset: dst=%06h required=%06h", dst_w, 22'h000000);
      end else $display("mid_reset: dst=%06h", dst_w);
      rst = 1'b0;
      tick();
      total++;
      if (dst_w !== 22'h3FF001) begin
         bad++;
         $display("FAIL mid_release: dst=%06h required=%06h", dst_w, 22'h3FF001);
      end else $display("mid_release: dst=%06h", dst_w);
      set_all(1'b0);
      @(negedge clk);
      total++;
      if (dst_w !== 22'h3FF001) begin
         bad++;
         $display("FAIL mid_hold: dst=%06h required=%06h", dst_w, 22'h3FF001);
      end else $display("mid_hold: dst=%06h", dst_w);
   endtask

   task automatic test_back_to_back();
      logic [21:0] exp_t [6] = '{22'h000000, 22'h3FF001, 22'h100000, 22'h002C00, 22'h3FF001, 22'h000000};
      for (int t = 0; t < 6; t++) begin
         case (t)
            0, 5: set_all(1'b0);
            1, 4: set_all(1'b1);
            2: begin set_all(1'b0); col_v[20] = 11'h001; end
            default: begin set_all(1'b0); col_v[10] = 11'h7FF; end
         endcase
         tick();
         total++;
         if (dst_w !== exp_t[t]) begin
            bad++;
            $display("FAIL b2b[%0d]: dst=%06h required=%06h", t, dst_w, exp_t[t]);
         end else $display("b2b[%0d]: dst=%06h", t, dst_w);
      end
   endtask

   task automatic test_random();
      logic [21:0] exp_v;
      int          bad_start;
      bad_start = bad;
      for (int n = 0; n < 10000; n++) begin
         case ($urandom_range(0, 9))
            0: set_all(1'b1);
            1: set_all(1'b0);
            default: for (int i = 0; i < 21; i++) col_v[i] = 11'($urandom) & col_mask(i);
         endcase
         tick();
         exp_v = model_sum();
         total++;
         if (dst_w !== exp_v) begin
            bad++;
            $display("FAIL random[%0d]: dst=%06h required=%06h", n, dst_w, exp_v);
         end
      end
      $display("random: 10000 cycles, %0d wrong", bad - bad_start);
   endtask

   initial begin
      rst = 1'b1;
      set_all(1'b0);
      test_reset();
      test_extremes();
      test_single_cols();
      test_reset_mid();
      test_back_to_back();
      test_random();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/compressor.md
COMPRESSOR -- requirements
Module: compressor

Interface
REQ-001 SHALL have no parameters; column heights and output width are fixed.
REQ-002 SHALL use one clock and a synchronous, active-high reset, with ports named clk and rst.
REQ-003 clk  input  1  rising-edge clock for all state.
REQ-004 rst  input  1  synchronous, active-high reset.
REQ-005 srcI  input  hI  bit column of weight 2^I, I = 0..20; hI = min(I+1, 21-I), so widths are 1,2,...,10,11,10,...,2,1.
REQ-006 Every bit of srcI SHALL be an independent addend of weight 2^I; bit order within a column SHALL NOT matter.
REQ-007 dstJ  output  1  bit J of the registered result S, J = 0..21; dst0 is the LSB.

Function
REQ-008 S SHALL equal the sum over I = 0..20 of popcount(srcI) * 2^I, exact and unsigned, with no truncation.
REQ-009 Maximum S = (2^11-1)^2 = 4190209 (0x3FF001), which fits in 22 bits; no overflow path SHALL exist.
REQ-010 Latency SHALL be 1 cycle: inputs sampled at edge k SHALL appear on dst0..dst21 after edge k and hold until edge k+1.
REQ-011 Reduction SHALL be combinational: a carry-save tree of full/half adders reducing every column to height <= 2, then one 22-bit carry-propagate add, then the output register.
REQ-012 There SHALL be no handshake; a new input set SHALL be accepted every cycle at full throughput.
REQ-013 Outputs SHALL depend only on the previous cycle's inputs, with no accumulation across cycles.
REQ-014 X/Z-free inputs SHALL always yield X-free outputs one cycle later.

Reset
REQ-015 While rst = 1 at a rising edge, every dstJ SHALL become 0 at that edge.
REQ-016 Reset SHALL take priority over input sampling; the first edge with rst = 0 SHALL register the current inputs normally.
REQ-017 Asserting rst mid-stream SHALL discard the in-flight result, with no partial state surviving.

Structure
REQ-018 A shared package SHALL hold the constants NUM_COLS = 21, OUT_W = 22 and the column-height function h(I).
REQ-019 One sub-module full_adder (3:2 counter: a, b, ci -> s, co) SHALL be instantiated throughout the tree; half adders MAY be inline logic.
REQ-020 The register stage SHALL be the only sequential logic; the compressor tree SHALL be purely combinational.
REQ-021 The target implementation size is 120-400 lines of RTL.

Verification
REQ-022 All inputs 0 -> S = 0x000000 one cycle later.
REQ-023 All inputs all-ones -> S = 0x3FF001 (4190209).
REQ-024 Only src20 = 1 -> S = 0x100000; only src10 = 11'h7FF -> S = 0x002C00 (11264).
REQ-025 Drive all-ones, assert rst for one edge, then release -> S = 0 after the reset edge and 0x3FF001 on the following edge.
REQ-026 10,000 random cycles compared against a software model of REQ-008 with 1-cycle delay, including back-to-back changes every cycle -> zero mismatches.
